id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk, reset.
REQ-002 Ports (name direction width meaning), in this order:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- stall  in  1  hold all stage registers
- flush  in  1  replace incoming instruction with bubble
- id_valid  in  1  ID holds a real instruction
- id_rs_addr, id_rt_addr, id_rd_addr  in  5 each  source/destination register numbers
- id_rs_data, id_rt_data  in  32 each  register-file read data
- id_imm  in  32  immediate, already extended
- id_shamt  in  5  shift amount
- id_alufun  in  6  ALU function code
- id_sign  in  1  signed compare select
- id_alusrc1  in  1  0: A=rs, 1: A=zero-extended shamt
- id_alusrc2  in  1  0: B=rt, 1: B=imm
- id_regwrite, id_memread, id_memwrite  in  1 each  control bits
- exmem_regwrite  in  1; exmem_rd  in  5; exmem_result  in  32  EX/MEM forward source
- memwb_regwrite  in  1; memwb_rd  in  5; memwb_result  in  32  MEM/WB forward source
- alu_a, alu_b  out  32 each  ALU operands
- alu_fun  out  6; alu_sign  out  1  ALU controls
- ex_store_data  out  32  forwarded rt for stores
- ex_rd  out  5; ex_regwrite, ex_memread, ex_memwrite, ex_valid  out  1 each
- load_use  out  1  load-use hazard request to upstream

Function
REQ-003 SHALL register all id_* inputs on the rising clk edge; latency ID->EX outputs exactly one cycle.
REQ-004 Register update priority SHALL be: reset > stall (hold) > flush or load_use (bubble) > load.
REQ-005 Bubble SHALL zero every stored field: valid, regwrite, memread, memwrite, addresses, data, imm, shamt, alufun (000000 = ADD), sign, alusrc bits.
REQ-006 Load SHALL store id_regwrite/id_memread/id_memwrite gated by id_valid; ex_valid = id_valid.
REQ-007 Forwarded rs (fwd_rs) SHALL be combinational from the stored operands: exmem_result if exmem_regwrite & exmem_rd!=0 & exmem_rd==stored rs_addr; else memwb_result if memwb_regwrite & memwb_rd!=0 & memwb_rd==stored rs_addr; else stored rs_data. fwd_rt is identical using stored rt_addr.
REQ-008 EX/MEM match SHALL win when both sources match.
REQ-009 alu_a = stored alusrc1 ? {27'b0, shamt} : fwd_rs; alu_b = stored alusrc2 ? imm : fwd_rt; ex_store_data = fwd_rt always.
REQ-010 alu_fun, alu_sign, ex_rd and control outputs SHALL come directly from stored fields.
REQ-011 load_use SHALL be combinational: ex_valid & ex_memread & ex_rd!=0 & (ex_rd==id_rs_addr | ex_rd==id_rt_addr) & id_valid.
REQ-012 When load_use=1 and stall=0, the next edge SHALL load a bubble; upstream holds IF/ID for that cycle.
REQ-013 load_use SHALL be forced 0 while stall=1 (no double bubble); during stall, forwarding stays live.
REQ-014 Register $0 SHALL never be a forward target or load_use cause.
REQ-015 Same-cycle WB write vs ID read is resolved by the register file, not this block.

Reset
REQ-016 While reset=1 at a clk edge, all stored fields SHALL become 0; after that edge alu_a=alu_b=0, alu_fun=000000, all control outputs and load_use=0.
REQ-017 reset SHALL override stall and flush in the same cycle.

Verification
REQ-018 Plain R-type: rs_data=5, rt_data=7, alufun=000000, no matches -> next cycle alu_a=5, alu_b=7, ex_regwrite=1.
REQ-019 Double forward: stored rs_addr=3, exmem_rd=3 result=0xAAAA, memwb_rd=3 result=0xBBBB, both regwrite=1 -> alu_a=0xAAAA; set exmem_rd=0 -> alu_a=0xBBBB.
REQ-020 Shift: alusrc1=1, shamt=4, rs_data=0xFFFF -> alu_a=4; alusrc2=1, imm=0xFFFFFFF0 -> alu_b=0xFFFFFFF0.
REQ-021 Load-use: EX holds lw rd=8 (memread=1); ID rs_addr=8 -> load_use=1, next cycle ex_valid=0, all controls 0; ex_rd=0 with memread -> load_use=0.
REQ-022 Stall/flush/reset priority: stall=1 and flush=1 -> outputs unchanged; then reset=1 with stall=1 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding from EX/MEM and MEM/WB,
// operand-source muxing and load-use hazard detection.
module id_ex_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        id_valid,
  input  logic [4:0]  id_rs_addr,
  input  logic [4:0]  id_rt_addr,
  input  logic [4:0]  id_rd_addr,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_shamt,
  input  logic [5:0]  id_alufun,
  input  logic        id_sign,
  input  logic        id_alusrc1,
  input  logic        id_alusrc2,
  input  logic        id_regwrite,
  input  logic        id_memread,
  input  logic        id_memwrite,
  input  logic        exmem_regwrite,
  input  logic [4:0]  exmem_rd,
  input  logic [31:0] exmem_result,
  input  logic        memwb_regwrite,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] memwb_result,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_fun,
  output logic        alu_sign,
  output logic [31:0] ex_store_data,
  output logic [4:0]  ex_rd,
  output logic        ex_regwrite,
  output logic        ex_memread,
  output logic        ex_memwrite,
  output logic        ex_valid,
  output logic        load_use
);

  logic        valid_q, regwrite_q, memread_q, memwrite_q;
  logic [4:0]  rs_addr_q, rt_addr_q, rd_addr_q, shamt_q;
  logic [31:0] rs_data_q, rt_data_q, imm_q;
  logic [5:0]  alufun_q;
  logic        sign_q, alusrc1_q, alusrc2_q;
  logic [31:0] fwd_rs, fwd_rt;

  // A load in EX whose destination is read by the instruction in ID must be
  // separated by a bubble; suppressed while stalled so only one bubble is made.
  always_comb begin
    load_use = 1'b0;
    if (!stall && valid_q && memread_q && (rd_addr_q != 5'd0) && id_valid &&
        ((rd_addr_q == id_rs_addr) || (rd_addr_q == id_rt_addr)))
      load_use = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || (!stall && (flush || load_use))) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      rs_addr_q  <= 5'd0;
      rt_addr_q  <= 5'd0;
      rd_addr_q  <= 5'd0;
      rs_data_q  <= 32'd0;
      rt_data_q  <= 32'd0;
      imm_q      <= 32'd0;
      shamt_q    <= 5'd0;
      alufun_q   <= 6'd0;
      sign_q     <= 1'b0;
      alusrc1_q  <= 1'b0;
      alusrc2_q  <= 1'b0;
    end else if (!stall) begin
      valid_q    <= id_valid;
      regwrite_q <= id_regwrite & id_valid;
      memread_q  <= id_memread & id_valid;
      memwrite_q <= id_memwrite & id_valid;
      rs_addr_q  <= id_rs_addr;
      rt_addr_q  <= id_rt_addr;
      rd_addr_q  <= id_rd_addr;
      rs_data_q  <= id_rs_data;
      rt_data_q  <= id_rt_data;
      imm_q      <= id_imm;
      shamt_q    <= id_shamt;
      alufun_q   <= id_alufun;
      sign_q     <= id_sign;
      alusrc1_q  <= id_alusrc1;
      alusrc2_q  <= id_alusrc2;
    end
  end

  // EX/MEM is the younger producer, so it is checked first; $0 never forwards.
  always_comb begin
    fwd_rs = rs_data_q;
    if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == rs_addr_q))
      fwd_rs = exmem_result;
    else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == rs_addr_q))
      fwd_rs = memwb_result;

    fwd_rt = rt_data_q;
    if (exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == rt_addr_q))
      fwd_rt = exmem_result;
    else if (memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == rt_addr_q))
      fwd_rt = memwb_result;
  end

  assign alu_a         = alusrc1_q ? {27'd0, shamt_q} : fwd_rs;
  assign alu_b         = alusrc2_q ? imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign alu_fun       = alufun_q;
  assign alu_sign      = sign_q;
  assign ex_rd         = rd_addr_q;
  assign ex_regwrite   = regwrite_q;
  assign ex_memread    = memread_q;
  assign ex_memwrite   = memwrite_q;
  assign ex_valid      = valid_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by random
// traffic compared against an instruction-level model of the EX stage.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, id_valid;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr, id_shamt;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [5:0]  id_alufun;
  logic        id_sign, id_alusrc1, id_alusrc2, id_regwrite, id_memread, id_memwrite;
  logic        exmem_regwrite, memwb_regwrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [5:0]  alu_fun;
  logic        alu_sign;
  logic [4:0]  ex_rd;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_valid, load_use;

  int total = 0;
  int bad = 0;

  id_ex_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_alufun(id_alufun), .id_sign(id_sign),
    .id_alusrc1(id_alusrc1), .id_alusrc2(id_alusrc2), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite),
    .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_sign(alu_sign),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_valid(ex_valid),
    .load_use(load_use)
  );

  always #5 clk = ~clk;

  // The instruction the model believes is sitting in EX.
  typedef struct packed {
    logic        valid, regwrite, memread, memwrite;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] rsd, rtd, imm;
    logic [5:0]  fun;
    logic        sign, src1, src2;
  } instr_t;

  instr_t m = '0;

  function automatic logic [31:0] operandValue(input logic [4:0] addr, input logic [31:0] fileVal);
    if (addr == 5'd0) return fileVal;
    if (exmem_regwrite && exmem_rd == addr) return exmem_result;
    if (memwb_regwrite && memwb_rd == addr) return memwb_result;
    return fileVal;
  endfunction

  function automatic logic modelLoadUse();
    if (stall || !id_valid) return 1'b0;
    if (!(m.valid && m.memread) || m.rd == 5'd0) return 1'b0;
    return (m.rd == id_rs_addr) || (m.rd == id_rt_addr);
  endfunction

  function automatic instr_t modelNext();
    instr_t n;
    if (reset) return '0;
    if (stall) return m;
    if (flush || modelLoadUse()) return '0;
    n.valid = id_valid;
    n.regwrite = id_valid && id_regwrite;
    n.memread = id_valid && id_memread;
    n.memwrite = id_valid && id_memwrite;
    n.rs = id_rs_addr; n.rt = id_rt_addr; n.rd = id_rd_addr; n.shamt = id_shamt;
    n.rsd = id_rs_data; n.rtd = id_rt_data; n.imm = id_imm;
    n.fun = id_alufun; n.sign = id_sign; n.src1 = id_alusrc1; n.src2 = id_alusrc2;
    return n;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkAll(input string tag);
    logic [31:0] ra, rb;
    #1;
    ra = operandValue(m.rs, m.rsd);
    rb = operandValue(m.rt, m.rtd);
    checkOutput({tag, ".alu_a"}, alu_a, m.src1 ? {27'd0, m.shamt} : ra);
    checkOutput({tag, ".alu_b"}, alu_b, m.src2 ? m.imm : rb);
    checkOutput({tag, ".store"}, ex_store_data, rb);
    checkOutput({tag, ".fun"}, {26'd0, alu_fun}, {26'd0, m.fun});
    checkOutput({tag, ".sign"}, {31'd0, alu_sign}, {31'd0, m.sign});
    checkOutput({tag, ".rd"}, {27'd0, ex_rd}, {27'd0, m.rd});
    checkOutput({tag, ".ctl"}, {28'd0, ex_valid, ex_regwrite, ex_memread, ex_memwrite},
                {28'd0, m.valid, m.regwrite, m.memread, m.memwrite});
    checkOutput({tag, ".load_use"}, {31'd0, load_use}, {31'd0, modelLoadUse()});
  endtask

  task automatic tick();
    instr_t n;
    n = modelNext();
    @(posedge clk);
    m = n;
    #2;
  endtask

  task automatic clearInputs();
    reset = 0; stall = 0; flush = 0; id_valid = 0;
    id_rs_addr = 0; id_rt_addr = 0; id_rd_addr = 0; id_shamt = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_alufun = 0;
    id_sign = 0; id_alusrc1 = 0; id_alusrc2 = 0;
    id_regwrite = 0; id_memread = 0; id_memwrite = 0;
    exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
    memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic applyStimulus();
    reset = ($urandom_range(0, 99) < 3);
    stall = ($urandom_range(0, 99) < 15);
    flush = ($urandom_range(0, 99) < 10);
    id_valid = ($urandom_range(0, 99) < 85);
    id_rs_addr = 5'($urandom_range(0, 3));
    id_rt_addr = 5'($urandom_range(0, 3));
    id_rd_addr = 5'($urandom_range(0, 3));
    id_shamt = 5'($urandom);
    id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
    id_alufun = 6'($urandom);
    id_sign = 1'($urandom); id_alusrc1 = 1'($urandom); id_alusrc2 = 1'($urandom);
    id_regwrite = 1'($urandom);
    id_memread = ($urandom_range(0, 99) < 40);
    id_memwrite = 1'($urandom);
    exmem_regwrite = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3)); exmem_result = $urandom;
    memwb_regwrite = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3)); memwb_result = $urandom;
  endtask

  initial begin
    clearInputs();
    @(negedge clk);

    // Reset wins over stall and flush.
    reset = 1; stall = 1; flush = 1;
    tick();
    clearInputs();
    checkAll("reset");
    checkOutput("reset.alu_a", alu_a, 32'd0);
    checkOutput("reset.valid", {31'd0, ex_valid}, 32'd0);

    // Plain R-type add.
    id_valid = 1; id_rs_addr = 1; id_rt_addr = 2; id_rd_addr = 3;
    id_rs_data = 5; id_rt_data = 7; id_regwrite = 1;
    tick();
    checkAll("rtype");
    checkOutput("rtype.a", alu_a, 32'd5);
    checkOutput("rtype.b", alu_b, 32'd7);
    checkOutput("rtype.rw", {31'd0, ex_regwrite}, 32'd1);

    // Both forward sources match; EX/MEM must win, then MEM/WB alone.
    id_rs_addr = 3;
    tick();
    exmem_regwrite = 1; exmem_rd = 3; exmem_result = 32'hAAAA;
    memwb_regwrite = 1; memwb_rd = 3; memwb_result = 32'hBBBB;
    checkAll("dfwd");
    checkOutput("dfwd.exmem", alu_a, 32'hAAAA);
    exmem_rd = 0;
    checkAll("dfwd0");
    checkOutput("dfwd.memwb", alu_a, 32'hBBBB);

    // Shift amount and immediate operand selection.
    clearInputs();
    id_valid = 1; id_alusrc1 = 1; id_shamt = 4; id_rs_data = 32'hFFFF;
    id_alusrc2 = 1; id_imm = 32'hFFFFFFF0;
    tick();
    checkAll("shift");
    checkOutput("shift.a", alu_a, 32'd4);
    checkOutput("shift.b", alu_b, 32'hFFFFFFF0);

    // Load-use hazard produces a bubble; a load into $0 does not.
    clearInputs();
    id_valid = 1; id_memread = 1; id_regwrite = 1; id_rd_addr = 8;
    tick();
    id_memread = 0; id_rd_addr = 9; id_rs_addr = 8;
    checkAll("lu");
    checkOutput("lu.req", {31'd0, load_use}, 32'd1);
    tick();
    checkAll("lu.bubble");
    checkOutput("lu.bubble.ctl", {28'd0, ex_valid, ex_regwrite, ex_memread, ex_memwrite}, 32'd0);
    id_rs_addr = 0; id_memread = 1; id_rd_addr = 0;
    tick();
    checkAll("lu.r0");
    checkOutput("lu.r0.req", {31'd0, load_use}, 32'd0);

    // Stall holds over flush; reset then clears despite stall.
    clearInputs();
    id_valid = 1; id_regwrite = 1; id_rs_data = 32'h1234; id_rs_addr = 5;
    tick();
    stall = 1; flush = 1; id_rs_data = 32'h9999; id_valid = 0;
    tick();
    checkAll("stall");
    checkOutput("stall.hold", alu_a, 32'h1234);
    checkOutput("stall.valid", {31'd0, ex_valid}, 32'd1);
    reset = 1;
    tick();
    reset = 0; stall = 0; flush = 0;
    checkAll("rst.stall");
    checkOutput("rst.stall.valid", {31'd0, ex_valid}, 32'd0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus();
      checkAll("rand");
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
